// File: rtl/g_stream_pkg.sv
// g_stream_pkg: shared stream defaults, word type and round-robin helper.
package g_stream_pkg;
  localparam int G_NUM_IN = 4;
  localparam int G_DATA_W = 32;
  localparam int G_TAG_W = 5;
  typedef struct packed {
    logic [G_DATA_W-1:0] bits;
    logic [G_TAG_W-1:0] tag;
  } g_word_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/g_fifo2.sv
// g_fifo2: two-entry FIFO; head register drives dout, cleared on reset.
module g_fifo2 #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rd, wr, do_push, do_pop;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= ~wr;
      end
      if (do_pop) rd <= ~rd;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/g_rr_collector_4.sv
// g_rr_collector_4: round-robin merge of NUM_IN tagged streams into a 2-entry buffer.
module g_rr_collector_4
  import g_stream_pkg::*;
#(
  parameter int NUM_IN = G_NUM_IN,
  parameter int DATA_W = G_DATA_W,
  parameter int TAG_W = G_TAG_W,
  parameter int IDX_W = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        io_in_valid,
  output logic [NUM_IN-1:0]        io_in_ready,
  input  logic [NUM_IN*DATA_W-1:0] io_in_bits,
  input  logic [NUM_IN*TAG_W-1:0]  io_in_tag,
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic [DATA_W-1:0]        io_out_bits,
  output logic [TAG_W-1:0]         io_out_tag,
  output logic [IDX_W-1:0]         io_chosen,
  output logic [1:0]               io_count
);
  localparam int W = DATA_W + TAG_W + IDX_W;
  logic [IDX_W-1:0] last_grant, sel;
  logic found, push, full, empty;
  logic [W-1:0] dout;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && io_in_valid[rr_next(int'(last_grant) + i, NUM_IN)]) begin
        found = 1'b1;
        sel = IDX_W'(rr_next(int'(last_grant) + i, NUM_IN));
      end
    end
  end
  // reset_n gates ready so nothing is offered while the block is held in reset
  assign push = found && !full && reset_n;
  assign io_in_ready = push ? NUM_IN'(1) << sel : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant <= IDX_W'(NUM_IN - 1);
    else if (push) last_grant <= sel;
  end
  g_fifo2 #(.W(W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(io_out_valid && io_out_ready),
    .din({io_in_bits[sel*DATA_W +: DATA_W], io_in_tag[sel*TAG_W +: TAG_W], sel}),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(io_count)
  );
  assign io_out_valid = !empty;
  assign {io_out_bits, io_out_tag, io_chosen} = dout;
endmodule
